// File: rtl/apb_host_bridge.sv
// APB initiator bridging a request/grant/response port to APB SETUP/ACCESS
// transfers, with wait-state absorption and a programmable hung-transfer timeout.
module apb_host_bridge #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      req_i,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic                      we_i,
    input  logic [31:0]               wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [31:0]               rdata_o,
    output logic                      err_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    // A disabled timeout still needs a legal one-bit counter.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } state_t;

    state_t                      state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0]   paddr_q;
    logic [31:0]                 pwdata_q;
    logic                        pwrite_q;
    logic [CNT_W-1:0]            stall_cnt_q;
    logic                        rvalid_q;
    logic                        err_q;
    logic [31:0]                 rdata_q;

    logic grant;
    logic complete;
    logic abort;
    logic timeout_hit;

    assign timeout_hit = (TIMEOUT_CYCLES > 0) && (stall_cnt_q == CNT_LAST);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        grant    = 1'b0;
        PSEL     = 1'b0;
        PENABLE  = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by reset so a held request is never granted while in reset.
                if (req_i && HRESETn) begin
                    grant   = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                PSEL    = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else if (timeout_hit) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            stall_cnt_q <= '0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            if (grant) begin
                paddr_q  <= addr_i;
                pwdata_q <= wdata_i;
                pwrite_q <= we_i;
            end

            if (state_q == SETUP) begin
                stall_cnt_q <= '0;
            end else if (state_q == ACCESS && !PREADY && stall_cnt_q != CNT_MAX) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end

            // PREADY wins over a coincident timeout, so abort is never set with complete.
            rvalid_q <= complete | abort;
            err_q    <= (complete & PSLVERR) | abort;
            if (complete) begin
                rdata_q <= pwrite_q ? 32'h0 : PRDATA;
            end else if (abort) begin
                rdata_q <= 32'h0;
            end
        end
    end

    assign gnt_o    = grant;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;
    assign PADDR    = paddr_q;
    assign PWDATA   = pwdata_q;
    assign PWRITE   = pwrite_q;

endmodule

// File: tb/tb_apb_host_bridge.sv
// Self-checking bench for apb_host_bridge: per-cycle handshake traces plus a
// response scoreboard filled when requests are issued and drained on rvalid_o.
module tb_apb_host_bridge;

    logic        HCLK;
    logic        HRESETn;
    logic        req_i;
    logic [11:0] addr_i;
    logic        we_i;
    logic [31:0] wdata_i;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    logic        gnt_o, rvalid_o, err_o, PWRITE, PSEL, PENABLE;
    logic [31:0] rdata_o, PWDATA;
    logic [11:0] PADDR;

    logic        gnt0, rvalid0, err0, pwrite0, psel0, penable0;
    logic [31:0] rdata0, pwdata0;
    logic [11:0] paddr0;

    int checks = 0;
    int errors = 0;

    logic [32:0] sb[$];
    logic [32:0] sb_exp;

    apb_host_bridge #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(4)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
        .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .err_o(err_o), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
        .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    apb_host_bridge #(.APB_ADDR_WIDTH(12), .TIMEOUT_CYCLES(0)) dut_nto (
        .HCLK(HCLK), .HRESETn(HRESETn), .req_i(req_i), .addr_i(addr_i), .we_i(we_i),
        .wdata_i(wdata_i), .gnt_o(gnt0), .rvalid_o(rvalid0), .rdata_o(rdata0),
        .err_o(err0), .PADDR(paddr0), .PWDATA(pwdata0), .PWRITE(pwrite0), .PSEL(psel0),
        .PENABLE(penable0), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Response monitor for the TIMEOUT_CYCLES=4 instance.
    always @(negedge HCLK) begin
        if (rvalid_o === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got rvalid rdata=%h err=%b, expected no response", rdata_o, err_o);
            end else begin
                sb_exp = sb.pop_front();
                if ({rdata_o, err_o} !== sb_exp) begin
                    errors++;
                    $display("FAIL sb_response: got rdata=%h err=%b expected rdata=%h err=%b",
                             rdata_o, err_o, sb_exp[32:1], sb_exp[0]);
                end
            end
        end else if (err_o !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL err_outside_response: got err=%b expected 0", err_o);
        end
    end

    // Runs one request from the cycle-0 grant; records {gnt,PSEL,PENABLE,rvalid} per cycle.
    task automatic run_xfer(input logic [11:0] a, input logic w, input logic [31:0] wd,
                            input int waits, input logic [31:0] prd, input logic slv,
                            input int ncyc, output logic [63:0] trace, output logic stable);
        trace  = '0;
        stable = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            req_i   = (c == 0);
            addr_i  = (c == 0) ? a : ~a;
            wdata_i = (c == 0) ? wd : ~wd;
            we_i    = (c == 0) ? w : ~w;
            PREADY  = (c >= 2 + waits);
            PRDATA  = prd;
            PSLVERR = slv;
            @(negedge HCLK);
            trace[c*4 +: 4] = {gnt_o, PSEL, PENABLE, rvalid_o};
            if (c >= 1 && c <= 2 + waits)
                stable &= (PADDR == a) && (PWDATA == wd) && (PWRITE == w);
            @(posedge HCLK); #1;
        end
        req_i   = 1'b0;
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
    endtask

    task automatic test_reset();
        HRESETn = 1'b0;
        req_i = 1'b1; addr_i = 12'hFFF; we_i = 1'b1; wdata_i = '1;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        @(negedge HCLK);
        checks++;
        if ({gnt_o, rvalid_o, rdata_o, err_o, PADDR, PWDATA, PWRITE, PSEL, PENABLE} !== '0) begin
            errors++;
            $display("FAIL reset_values: got gnt=%b rvalid=%b rdata=%h err=%b paddr=%h pwdata=%h pwrite=%b psel=%b pen=%b expected all 0",
                     gnt_o, rvalid_o, rdata_o, err_o, PADDR, PWDATA, PWRITE, PSEL, PENABLE);
        end
        req_i = 1'b0;
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        @(negedge HCLK);
        checks++;
        if ({gnt_o, rvalid_o, PSEL, PENABLE} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected 0000", {gnt_o, rvalid_o, PSEL, PENABLE});
        end
        @(posedge HCLK); #1;
    endtask

    task automatic test_zero_wait_read();
        logic [63:0] tr, exp;
        logic st;
        exp = {4'b0000, 4'b0001, 4'b0110, 4'b0100, 4'b1000};
        sb.push_back({32'hDEADBEEF, 1'b0});
        run_xfer(12'h004, 1'b0, 32'h0, 0, 32'hDEADBEEF, 1'b0, 5, tr, st);
        checks++;
        if (tr !== exp) begin
            errors++;
            $display("FAIL zero_wait_trace: got %h expected %h", tr, exp);
        end
        checks++;
        if (!st) begin
            errors++;
            $display("FAIL zero_wait_paddr: got unstable PADDR/PWRITE expected addr 004 read");
        end
        @(negedge HCLK);
        checks++;
        if (rdata_o !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL rdata_hold: got %h expected deadbeef", rdata_o);
        end
        @(posedge HCLK); #1;
    endtask

    task automatic test_write_wait_states();
        logic [63:0] tr, exp;
        logic st;
        exp = {4'b0000, 4'b0001, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0100, 4'b1000};
        // Completion lands on the same cycle the stall counter reaches the timeout point.
        sb.push_back({32'h0, 1'b0});
        run_xfer(12'h010, 1'b1, 32'h0000_00A5, 3, 32'h1234_5678, 1'b0, 8, tr, st);
        checks++;
        if (tr !== exp) begin
            errors++;
            $display("FAIL write_wait_trace: got %h expected %h", tr, exp);
        end
        checks++;
        if (!st) begin
            errors++;
            $display("FAIL write_stable: got changing PADDR/PWDATA/PWRITE expected 010/000000a5/1");
        end
    endtask

    task automatic test_slave_error();
        logic [63:0] tr, exp;
        logic st;
        exp = {4'b0000, 4'b0001, 4'b0110, 4'b0100, 4'b1000};
        sb.push_back({32'hCAFE_0001, 1'b1});
        run_xfer(12'h020, 1'b0, 32'h0, 0, 32'hCAFE_0001, 1'b1, 5, tr, st);
        checks++;
        if (tr !== exp) begin
            errors++;
            $display("FAIL slverr_trace: got %h expected %h", tr, exp);
        end
        sb.push_back({32'h1357_9BDF, 1'b0});
        run_xfer(12'h024, 1'b0, 32'h0, 1, 32'h1357_9BDF, 1'b0, 6, tr, st);
        exp = {4'b0000, 4'b0001, 4'b0110, 4'b0110, 4'b0100, 4'b1000};
        checks++;
        if (tr !== exp) begin
            errors++;
            $display("FAIL good_read_trace: got %h expected %h", tr, exp);
        end
    endtask

    task automatic test_timeout();
        logic [63:0] tr, exp;
        logic st;
        exp = {4'b0000, 4'b0001, 4'b0110, 4'b0110, 4'b0110, 4'b0110, 4'b0100, 4'b1000};
        sb.push_back({32'h0, 1'b1});
        run_xfer(12'h02C, 1'b0, 32'h0, 1000, 32'hFFFF_FFFF, 1'b0, 8, tr, st);
        checks++;
        if (tr !== exp) begin
            errors++;
            $display("FAIL timeout_trace: got %h expected %h", tr, exp);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] tr, exp;
        logic [11:0] a2_seen;
        logic [31:0] rd [0:6];
        exp = {4'b0001, 4'b0110, 4'b0100, 4'b1001, 4'b0110, 4'b0100, 4'b1000};
        rd = '{32'h0, 32'h0, 32'hA1A1_0001, 32'h0, 32'h0, 32'hB2B2_0002, 32'h0};
        tr = '0;
        a2_seen = '0;
        sb.push_back({32'hA1A1_0001, 1'b0});
        sb.push_back({32'hB2B2_0002, 1'b0});
        for (int c = 0; c < 7; c++) begin
            req_i   = (c <= 3);
            addr_i  = (c < 3) ? 12'h040 : 12'h044;
            we_i    = 1'b0;
            wdata_i = 32'h0;
            PREADY  = 1'b1;
            PRDATA  = rd[c];
            PSLVERR = 1'b0;
            @(negedge HCLK);
            tr[c*4 +: 4] = {gnt_o, PSEL, PENABLE, rvalid_o};
            if (c == 4) a2_seen = PADDR;
            @(posedge HCLK); #1;
        end
        req_i  = 1'b0;
        PREADY = 1'b0;
        checks++;
        if (tr !== exp) begin
            errors++;
            $display("FAIL b2b_trace: got %h expected %h", tr, exp);
        end
        checks++;
        if (a2_seen !== 12'h044) begin
            errors++;
            $display("FAIL b2b_paddr: got %h expected 044", a2_seen);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [63:0] tr, exp;
        logic st;
        logic bad;
        req_i = 1'b1; addr_i = 12'h030; we_i = 1'b1; wdata_i = 32'h5555_AAAA;
        PREADY = 1'b0; PSLVERR = 1'b0;
        sb.push_back({32'h0, 1'b0});
        @(posedge HCLK); #1;
        req_i = 1'b0;
        @(posedge HCLK); #1;
        @(posedge HCLK); #1;
        checks++;
        if ({PSEL, PENABLE} !== 2'b11) begin
            errors++;
            $display("FAIL mid_access_precond: got psel/pen=%b expected 11", {PSEL, PENABLE});
        end
        req_i = 1'b1;
        #1 HRESETn = 1'b0;
        #1;
        checks++;
        if ({PSEL, PENABLE, gnt_o, rvalid_o, err_o, PWRITE, PADDR, PWDATA, rdata_o} !== '0) begin
            errors++;
            $display("FAIL async_reset: got psel=%b pen=%b gnt=%b rvalid=%b err=%b pwrite=%b paddr=%h pwdata=%h rdata=%h expected all 0",
                     PSEL, PENABLE, gnt_o, rvalid_o, err_o, PWRITE, PADDR, PWDATA, rdata_o);
        end
        sb.delete();
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;
        req_i   = 1'b0;
        PREADY  = 1'b1;
        @(posedge HCLK); #1;
        bad = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge HCLK);
            if ({PSEL, rvalid_o} !== 2'b00) bad = 1'b1;
            @(posedge HCLK); #1;
        end
        PREADY = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL no_resp_after_reset: got activity expected psel=0 rvalid=0");
        end
        exp = {4'b0000, 4'b0001, 4'b0110, 4'b0100, 4'b1000};
        sb.push_back({32'h600D_F00D, 1'b0});
        run_xfer(12'h034, 1'b0, 32'h0, 0, 32'h600D_F00D, 1'b0, 5, tr, st);
        checks++;
        if (tr !== exp) begin
            errors++;
            $display("FAIL fresh_read_trace: got %h expected %h", tr, exp);
        end
    endtask

    task automatic test_timeout_disabled();
        logic bad;
        HRESETn = 1'b0;
        req_i = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
        sb.delete();
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        // The TIMEOUT_CYCLES=4 instance sees the same stuck slave and aborts.
        sb.push_back({32'h0, 1'b1});
        bad = 1'b0;
        for (int c = 0; c < 1002; c++) begin
            req_i  = (c == 0);
            addr_i = 12'h050;
            we_i   = 1'b0;
            PREADY = 1'b0;
            PRDATA = 32'h0BAD_F00D;
            @(negedge HCLK);
            if (c >= 2 && ({psel0, penable0, rvalid0} !== 3'b110)) bad = 1'b1;
            @(posedge HCLK); #1;
        end
        req_i = 1'b0;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL no_timeout_hold: got exit from ACCESS expected 1000 ACCESS cycles without rvalid");
        end
        PREADY = 1'b1;
        @(posedge HCLK); #1;
        PREADY = 1'b0;
        @(negedge HCLK);
        checks++;
        if ({rvalid0, err0, rdata0, psel0} !== {1'b1, 1'b0, 32'h0BAD_F00D, 1'b0}) begin
            errors++;
            $display("FAIL no_timeout_complete: got rvalid=%b err=%b rdata=%h psel=%b expected 1/0/0badf00d/0",
                     rvalid0, err0, rdata0, psel0);
        end
        @(posedge HCLK); #1;
    endtask

    initial begin
        test_reset();
        test_zero_wait_read();
        test_write_wait_states();
        test_slave_error();
        test_timeout();
        test_back_to_back();
        test_reset_mid_access();
        test_timeout_disabled();
        repeat (2) @(posedge HCLK);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d outstanding responses expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_host_bridge.md
# apb_host_bridge

APB initiator that turns a simple request/grant/response port into APB SETUP/ACCESS transfers. It sits upstream of APB slaves such as the event, interrupt and sleep units and drives their PSEL/PENABLE/PADDR/PWDATA/PWRITE. It also absorbs PREADY wait states, returns PRDATA/PSLVERR as a one-cycle response, and aborts hung transfers with a programmable timeout.

## Interface
- APB_ADDR_WIDTH, 12, width of addr_i/PADDR
- TIMEOUT_CYCLES, 255, max ACCESS cycles with PREADY low before abort; 0 disables timeout
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- HCLK  in  1  clock; all state updates on posedge
- HRESETn  in  1  asynchronous active-low reset
- req_i  in  1  request valid; held with addr/we/wdata until granted
- addr_i  in  APB_ADDR_WIDTH  byte address
- we_i  in  1  1 = write, 0 = read
- wdata_i  in  32  write data
- gnt_o  out  1  request accepted this cycle (combinational)
- rvalid_o  out  1  one-cycle response pulse
- rdata_o  out  32  read data; 0 for writes and aborts
- err_o  out  1  response error (PSLVERR or timeout), valid with rvalid_o
- PADDR  out  APB_ADDR_WIDTH  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB direction
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: gnt_o = req_i. On req_i, capture addr_i/we_i/wdata_i into PADDR/PWRITE/PWDATA registers and go to SETUP.
- SETUP: PSEL=1, PENABLE=0. Always goes to ACCESS next cycle.
- ACCESS: PSEL=1, PENABLE=1.
  - PREADY=1: register rdata_o (PRDATA if read, else 0) and err_o = PSLVERR. Pulse rvalid_o next cycle. Go to IDLE.
  - PREADY=0: stay in ACCESS and increment the stall counter.
- Stall counter: width $clog2(TIMEOUT_CYCLES+1). Cleared on entering ACCESS; saturates, no wrap.
  - If TIMEOUT_CYCLES>0, PREADY=0 and counter == TIMEOUT_CYCLES-1: abort. Go to IDLE, and next cycle pulse rvalid_o with err_o=1, rdata_o=0.
- PADDR/PWDATA/PWRITE are stable from SETUP through the end of ACCESS. They keep their last value in IDLE and change only on grant.
- gnt_o is 0 in SETUP and ACCESS. req_i held there is ignored until IDLE.
- PRDATA and PSLVERR are sampled only when PREADY=1 in ACCESS.
- A simultaneous timeout and PREADY=1 in the same cycle is a normal completion: PREADY wins and err_o = PSLVERR.
- rvalid_o and err_o are 0 in every cycle except the response cycle. rdata_o holds its last value between responses.

## Timing
- Reset values: gnt_o=0 (req_i ignored in reset), rvalid_o=0, rdata_o=0, err_o=0, PADDR=0, PWDATA=0, PWRITE=0, PSEL=0, PENABLE=0. FSM=IDLE, counter=0.
- Reset mid-transfer: PSEL and PENABLE drop immediately (asynchronous); no response is issued for the aborted transfer.
- Zero-wait transfer, taking the grant cycle as cycle 0:
  - cycle 0: grant
  - cycle 1: SETUP
  - cycle 2: ACCESS
  - cycle 3: rvalid_o, FSM in IDLE; a new grant is possible in cycle 3
- Throughput: one transfer per 3 cycles plus N wait states.
- Timeout abort: ACCESS lasts exactly TIMEOUT_CYCLES cycles. rvalid_o arrives on the following cycle, with PSEL=0 in that same cycle.

## Test plan
- Zero-wait read: req_i=1, addr_i=0x004, we_i=0 at cycle 0; slave PREADY=1, PRDATA=0xDEADBEEF.
  - Required: gnt_o cycle 0, PSEL cycle 1, PENABLE cycles 2 only, rvalid_o cycle 3 with rdata_o=0xDEADBEEF, err_o=0.
- Write with 3 wait states: addr_i=0x010, wdata_i=0x0000_00A5, PREADY low for the first 3 ACCESS cycles.
  - Required: PENABLE cycles 2–5, PWDATA=0xA5 and PWRITE=1 stable cycles 1–5, rvalid_o cycle 6 with rdata_o=0, err_o=0.
- Slave error: read with PSLVERR=1, PREADY=1.
  - Required: rvalid_o with err_o=1, rdata_o=PRDATA.
  - Following good read: err_o=0.
- Timeout (TIMEOUT_CYCLES=4, PREADY stuck 0).
  - Required: PENABLE high cycles 2–5, PSEL=0 at cycle 6, rvalid_o cycle 6 with err_o=1, rdata_o=0.
  - With TIMEOUT_CYCLES=0: transfer stays in ACCESS for 1000 cycles, no rvalid_o.
- Back-to-back: req_i held high for two zero-wait reads.
  - Required: gnt_o cycles 0 and 3, rvalid_o cycles 3 and 6, PSEL low in cycle 3.
- Reset mid-ACCESS: HRESETn low during a wait state.
  - Required: PSEL/PENABLE 0 within the same cycle, all outputs at reset values, no rvalid_o after release.
  - A fresh read then completes normally.
